// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state type for the SRAM-backed write slave.
package axi_pkg;

  // Widths of the AXI signals seen on the slave side of the interconnect.
  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_SIZE_BITS = 3;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_STRB_BITS = 4;

  // BRESP codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // The only AWSIZE/AWBURST combination this slave supports.
  localparam logic [AXI_SIZE_BITS-1:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0]               AXI_BURST_INCR = 2'd1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_e;

endpackage

// File: rtl/slave_write_resp.sv
// B-channel holding register: loads ID and status on the last W beat and
// keeps BVALID/BID/BRESP stable until the interconnect takes the response.
module slave_write_resp
  import axi_pkg::*;
#(
  parameter int unsigned ID_BITS = AXI_IDS_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [ID_BITS-1:0] load_id,
  input  logic               load_err,
  input  logic               ready,
  output logic               valid,
  output logic [ID_BITS-1:0] id,
  output logic [1:0]         resp
);

  logic               valid_q;
  logic [ID_BITS-1:0] id_q;
  logic [1:0]         resp_q;

  // Response register; ID and code are only rewritten by a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      resp_q  <= OKAY;
    end else if (load) begin
      valid_q <= 1'b1;
      id_q    <= load_id;
      resp_q  <= load_err ? SLVERR : OKAY;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign id    = id_q;
  assign resp  = resp_q;

endmodule

// File: rtl/slave_write.sv
// AXI write-channel slave: one AW at a time, each W beat becomes a
// single-cycle byte-masked SRAM write, then a B response with the stored ID.
module slave_write
  import axi_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 14,
  parameter int unsigned MAX_LEN       = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_IDS_BITS-1:0]  AWID_S,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_S,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_S,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE_S,
  input  logic [1:0]               AWBURST_S,
  input  logic                     AWVALID_S,
  output logic                     AWREADY_S,
  input  logic [AXI_DATA_BITS-1:0] WDATA_S,
  input  logic [AXI_STRB_BITS-1:0] WSTRB_S,
  input  logic                     WLAST_S,
  input  logic                     WVALID_S,
  output logic                     WREADY_S,
  output logic [AXI_IDS_BITS-1:0]  BID_S,
  output logic [1:0]               BRESP_S,
  output logic                     BVALID_S,
  input  logic                     BREADY_S,
  output logic                     mem_cs,
  output logic [3:0]               mem_web,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [31:0]              mem_di
);

  // Extra bit so beats past AWLEN never alias back onto a valid count.
  localparam int unsigned CntBits = AXI_LEN_BITS + 1;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_BITS-1:0]  ptr_q, ptr_d;
  logic [AXI_LEN_BITS-1:0]   len_q, len_d;
  logic [CntBits-1:0]        cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [AXI_IDS_BITS-1:0]   id_q, id_d;
  logic                      resp_load;
  logic                      last_mismatch;
  logic                      beyond_len;

  // Address bits outside the word pointer are ignored.
  logic unused_addr;
  assign unused_addr = ^{AWADDR_S[AXI_ADDR_BITS-1:MEM_ADDR_BITS+2], AWADDR_S[1:0]};

  assign last_mismatch = WLAST_S ? (cnt_q != {1'b0, len_q}) : (cnt_q == {1'b0, len_q});
  assign beyond_len    = cnt_q > {1'b0, len_q};

  // Transaction state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      id_q    <= id_d;
    end
  end

  // Next-state, handshake readies and SRAM strobes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    id_d      = id_q;
    resp_load = 1'b0;
    AWREADY_S = 1'b0;
    WREADY_S  = 1'b0;
    mem_cs    = 1'b0;
    mem_web   = 4'b1111;
    mem_addr  = ptr_q;
    mem_di    = '0;

    unique case (state_q)
      IDLE: begin
        // Gated by rst so the port reads 0 while reset is held.
        AWREADY_S = !rst;
        if (AWVALID_S && !rst) begin
          id_d    = AWID_S;
          ptr_d   = AWADDR_S[MEM_ADDR_BITS+1:2];
          len_d   = AWLEN_S;
          cnt_d   = '0;
          err_d   = (AWSIZE_S != AXI_SIZE_WORD) || (AWBURST_S != AXI_BURST_INCR) ||
                    (32'(AWLEN_S) > MAX_LEN);
          state_d = DATA;
        end
      end
      DATA: begin
        WREADY_S = 1'b1;
        if (WVALID_S) begin
          mem_cs  = 1'b1;
          mem_di  = WDATA_S;
          mem_web = beyond_len ? 4'b1111 : WSTRB_S;
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (last_mismatch) begin
            err_d = 1'b1;
          end
          if (WLAST_S) begin
            resp_load = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (BVALID_S && BREADY_S) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  slave_write_resp #(
    .ID_BITS(AXI_IDS_BITS)
  ) u_resp (
    .clk      (clk),
    .rst      (rst),
    .load     (resp_load),
    .load_id  (id_q),
    .load_err (err_d),
    .ready    (BREADY_S),
    .valid    (BVALID_S),
    .id       (BID_S),
    .resp     (BRESP_S)
  );

endmodule

// File: tb/tb_slave_write.sv
// Scoreboard bench for slave_write: directed AW/W/B sequences push expected
// SRAM writes and B responses; a negedge monitor pops and compares.
module tb_slave_write;
  import axi_pkg::*;

  localparam int unsigned MAB = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'd1;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hf;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        mem_cs;
  logic [3:0]  mem_web;
  logic [MAB-1:0] mem_addr;
  logic [31:0] mem_di;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {logic [MAB-1:0] addr; logic [3:0] web; logic [31:0] di;} wr_t;
  typedef struct {logic [7:0] id; logic [1:0] resp;} b_t;
  wr_t wr_q[$];
  b_t  b_q[$];

  logic [31:0] sram [0:(1<<MAB)-1];

  slave_write #(
    .MEM_ADDR_BITS(MAB),
    .MAX_LEN      (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .AWID_S   (awid),
    .AWADDR_S (awaddr),
    .AWLEN_S  (awlen),
    .AWSIZE_S (awsize),
    .AWBURST_S(awburst),
    .AWVALID_S(awvalid),
    .AWREADY_S(awready),
    .WDATA_S  (wdata),
    .WSTRB_S  (wstrb),
    .WLAST_S  (wlast),
    .WVALID_S (wvalid),
    .WREADY_S (wready),
    .BID_S    (bid),
    .BRESP_S  (bresp),
    .BVALID_S (bvalid),
    .BREADY_S (bready),
    .mem_cs   (mem_cs),
    .mem_web  (mem_web),
    .mem_addr (mem_addr),
    .mem_di   (mem_di)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Behavioural SRAM: active-low byte enables.
  always @(posedge clk) begin
    if (mem_cs) begin
      for (int b = 0; b < 4; b++) begin
        if (!mem_web[b]) sram[mem_addr][b*8 +: 8] <= mem_di[b*8 +: 8];
      end
    end
  end

  // Monitor: compare every SRAM access and every B handshake against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_cs) begin
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_web", 32'(mem_web), 32'(e.web));
          chk("wr_di", mem_di, e.di);
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) fail_now("unexpected_b");
        else begin
          b_t e;
          e = b_q.pop_front();
          chk("bid", 32'(bid), 32'(e.id));
          chk("bresp", 32'(bresp), 32'(e.resp));
        end
      end
    end
  end

  task automatic aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [2:0] size);
    int k;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'd1; awvalid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (awready) break;
    end
    if (k == 50) fail_now("aw_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w(input logic [31:0] d, input logic [3:0] s, input logic l, input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("cs_in_gap", 32'(mem_cs), 32'd0);
      @(posedge clk); #1;
    end
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wready) break;
    end
    if (k == 50) fail_now("w_timeout");
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bvalid && bready) break;
    end
    if (k == 50) fail_now("b_timeout");
    @(posedge clk); #1;
  endtask

  task automatic push_wr(input logic [MAB-1:0] a, input logic [3:0] web, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.web = web; e.di = d;
    wr_q.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] id, input logic [1:0] r);
    b_t e;
    e.id = id; e.resp = r;
    b_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"}, 32'(wready), 32'd0);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, "_bid"}, 32'(bid), 32'd0);
    chk({tag, "_bresp"}, 32'(bresp), 32'd0);
    chk({tag, "_mem_cs"}, 32'(mem_cs), 32'd0);
    chk({tag, "_mem_web"}, 32'(mem_web), 32'hf);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_di"}, mem_di, 32'd0);
  endtask

  initial begin
    sram[8] = 32'h1122_3344;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word, full strobe.
    push_wr(14'd4, 4'b0000, 32'hDEAD_BEEF);
    push_b(8'h12, OKAY);
    aw(8'h12, 32'h0000_0010, 4'd0, 3'd2);
    w(32'hDEAD_BEEF, 4'b0000, 1'b1, 0);
    chk("b_latency", 32'(bvalid), 32'd1);
    b_wait();
    chk("idle_after_b", 32'(awready), 32'd1);

    // Byte 0 only.
    push_wr(14'd8, 4'b1110, 32'h0000_00AB);
    push_b(8'h34, OKAY);
    aw(8'h34, 32'h0000_0020, 4'd0, 3'd2);
    w(32'h0000_00AB, 4'b1110, 1'b1, 0);
    b_wait();
    chk("byte_readback", sram[8], 32'h1122_33AB);

    // Burst wrapping the 14-bit word pointer, with WVALID gaps.
    push_wr(14'h3FFE, 4'b0000, 32'hA000_0000);
    push_wr(14'h3FFF, 4'b0000, 32'hA000_0001);
    push_wr(14'h0000, 4'b0000, 32'hA000_0002);
    push_wr(14'h0001, 4'b0000, 32'hA000_0003);
    push_b(8'h56, OKAY);
    aw(8'h56, 32'h0003_FFF8, 4'd3, 3'd2);
    w(32'hA000_0000, 4'b0000, 1'b0, 0);
    w(32'hA000_0001, 4'b0000, 1'b0, 2);
    w(32'hA000_0002, 4'b0000, 1'b0, 1);
    w(32'hA000_0003, 4'b0000, 1'b1, 3);
    b_wait();

    // Early WLAST on beat 1 of a len-3 burst.
    push_wr(14'h40, 4'b0000, 32'h0000_1111);
    push_wr(14'h41, 4'b0101, 32'h0000_2222);
    push_b(8'h78, SLVERR);
    aw(8'h78, 32'h0000_0100, 4'd3, 3'd2);
    w(32'h0000_1111, 4'b0000, 1'b0, 0);
    w(32'h0000_2222, 4'b0101, 1'b1, 0);
    b_wait();
    chk("idle_after_err", 32'(awready), 32'd1);

    // Unsupported AWSIZE answered with SLVERR; masked strobe still handshakes.
    push_wr(14'h50, 4'b1111, 32'h5555_5555);
    push_b(8'h5A, SLVERR);
    aw(8'h5A, 32'h0000_0140, 4'd0, 3'd1);
    w(32'h5555_5555, 4'b1111, 1'b1, 0);
    b_wait();

    // BREADY held low for five cycles.
    push_wr(14'h80, 4'b0000, 32'hCAFE_F00D);
    push_b(8'h9A, OKAY);
    bready = 1'b0;
    aw(8'h9A, 32'h0000_0200, 4'd0, 3'd2);
    w(32'hCAFE_F00D, 4'b0000, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_bvalid", 32'(bvalid), 32'd1);
      chk("hold_bid", 32'(bid), 32'h9A);
      chk("hold_bresp", 32'(bresp), 32'(OKAY));
      chk("hold_awready", 32'(awready), 32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    b_wait();
    chk("awready_after_b", 32'(awready), 32'd1);

    // Reset asserted during beat 2 of a len-3 burst.
    push_wr(14'hC0, 4'b0000, 32'hB000_0000);
    push_wr(14'hC1, 4'b0000, 32'hB000_0001);
    aw(8'hBC, 32'h0000_0300, 4'd3, 3'd2);
    w(32'hB000_0000, 4'b0000, 1'b0, 0);
    w(32'hB000_0001, 4'b0000, 1'b0, 0);
    wdata = 32'hB000_0002; wstrb = 4'b0000; wvalid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("midburst");
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("aw_after_reset", 32'(awready), 32'd1);
    push_wr(14'h10, 4'b0000, 32'h0BAD_CAFE);
    push_b(8'hDE, OKAY);
    aw(8'hDE, 32'h0000_0040, 4'd0, 3'd2);
    w(32'h0BAD_CAFE, 4'b0000, 1'b1, 0);
    b_wait();

    repeat (3) @(posedge clk);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("b_queue_drained", 32'(b_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
